// File: rtl/count_sched_pkg.sv
// Shared encodings and default sizes for the shared-counter scheduler.
package count_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 4;
    localparam int DEF_LW   = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/count_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester with req high,
// searching upward from the slot after last_winner, with wrap.
module rr_pick
    import count_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_winner,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    int slot;

    // Walk from the farthest slot to the nearest so the nearest match wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        slot   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            slot = int'(last_winner) + k;
            if (slot >= NREQ) slot = slot - NREQ;
            if (req[slot[IW-1:0]]) begin
                valid  = 1'b1;
                winner = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin scheduler sharing one wrapping counter among requesters;
// each winner gets exactly len increments followed by a done pulse.
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW,
    parameter int LW   = DEF_LW
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*LW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               enable,
    output logic [CW-1:0]      count,
    output logic               busy
);

    localparam int IW = idx_width(NREQ);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [IW-1:0] winner;
    logic [IW-1:0] last_winner;
    logic [IW-1:0] pick_winner;
    logic          pick_valid;
    logic [LW-1:0] remaining;
    logic [LW-1:0] pick_len;

    rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_pick (
        .req        (req),
        .last_winner(last_winner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign pick_len = len[int'(pick_winner)*LW +: LW];

    always_ff @(posedge clock) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (!pick_valid)         state_next = IDLE;
                else if (pick_len != '0) state_next = RUN;
                else                     state_next = DONE;
            end
            RUN:     state_next = (remaining == LW'(1)) ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointer resets to the last slot so requester 0 leads the first search.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            count       <= '0;
            winner      <= '0;
            remaining   <= '0;
            last_winner <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner    <= pick_winner;
                        remaining <= pick_len;
                    end
                end
                RUN: begin
                    count     <= count + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                DONE:    last_winner <= winner;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt    = '0;
        done   = '0;
        enable = 1'b0;
        busy   = 1'b0;
        case (state)
            RUN: begin
                gnt[winner] = 1'b1;
                enable      = 1'b1;
                busy        = 1'b1;
            end
            DONE: begin
                gnt[winner]  = 1'b1;
                done[winner] = 1'b1;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_count_scheduler.sv
// Self-checking bench: vector table, hand sequences and random bursts
// against a transaction-level model of the scheduler.
module tb_count_scheduler;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [15:0] len   = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        enable;
    logic [3:0]  count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int model_ptr = 3;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] l;
        int          w;
        int          cnt;
    } vec_t;

    vec_t tbl[8];

    count_scheduler #(
        .NREQ(4),
        .CW  (4),
        .LW  (4)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .enable(enable),
        .count (count),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // One arbitration from idle; req is dropped and len scrambled after the grant.
    task automatic do_burst(input logic [3:0] r, input logic [15:0] l, input int w);
        int n;
        int g;
        n = int'((l >> (w * 4)) & 16'hF);
        g = 1 << w;
        @(negedge clock);
        req = r;
        len = l;
        @(posedge clock);
        #1;
        chk("grant_e0", int'(gnt), g);
        chk("busy_e0", int'(busy), 1);
        chk("enable_e0", int'(enable), (n != 0) ? 1 : 0);
        chk("done_e0", int'(done), (n == 0) ? g : 0);
        chk("count_e0", int'(count), model_count);
        req = '0;
        len = 16'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            chk("count_run", int'(count), (model_count + k) % 16);
            chk("grant_run", int'(gnt), g);
            chk("enable_run", int'(enable), (k < n) ? 1 : 0);
            chk("done_run", int'(done), (k == n) ? g : 0);
        end
        @(posedge clock);
        #1;
        chk("grant_idle", int'(gnt), 0);
        chk("done_idle", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("enable_idle", int'(enable), 0);
        model_count = (model_count + n) % 16;
        model_ptr = w;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 16'h0003, 0, 3};
        tbl[1] = '{4'b0100, 16'hF0F7, 2, 3};
        tbl[2] = '{4'b1111, 16'h1111, 3, 4};
        tbl[3] = '{4'b1010, 16'h2050, 1, 9};
        tbl[4] = '{4'b1010, 16'h5040, 3, 14};
        tbl[5] = '{4'b0001, 16'h0005, 0, 3};
        tbl[6] = '{4'b0011, 16'h0021, 1, 5};
        tbl[7] = '{4'b0001, 16'h000F, 0, 4};

        rst_n = 1'b0;
        req = 4'b1111;
        len = 16'h1111;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        req = '0;
        @(negedge clock);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_burst(tbl[i].r, tbl[i].l, tbl[i].w);
            chk("tbl_count", int'(count), tbl[i].cnt);
        end

        // Reset during a 6-long burst after two increments.
        @(negedge clock);
        req = 4'b0001;
        len = 16'h0006;
        @(posedge clock);
        #1;
        chk("abort_grant", int'(gnt), 1);
        req = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_pre", int'(count), (model_count + 2) % 16);
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_count", int'(count), 0);
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clock);
        #1;
        chk("abort_done2", int'(done), 0);
        @(negedge clock);
        rst_n = 1'b1;
        model_count = 0;
        model_ptr = 3;
        do_burst(4'b1010, 16'h4030, 1);

        // Continuous full request, single-increment bursts.
        @(negedge clock);
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        model_count = 0;
        model_ptr = 3;
        req = 4'b1111;
        len = 16'h1111;
        for (int b = 0; b < 5; b++) begin
            @(posedge clock);
            #1;
            chk("rot_grant", int'(gnt), 1 << (b % 4));
            chk("rot_enable", int'(enable), 1);
            @(posedge clock);
            #1;
            chk("rot_done", int'(done), 1 << (b % 4));
            chk("rot_count", int'(count), b + 1);
            @(posedge clock);
            #1;
            chk("rot_idle", int'(busy), 0);
        end
        req = '0;
        model_count = 5;
        model_ptr = 0;

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  r;
            logic [15:0] l;
            r = 4'($urandom_range(1, 15));
            l = 16'($urandom);
            if ($urandom_range(0, 3) == 0) l = l & 16'h3333;
            do_burst(r, l, model_pick(r, model_ptr));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clock);
        end
        chk("final_count", int'(count), model_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
